mem_dma: RTL and testbench

MEM_DMA -- requirements
Module: mem_dma

---
 rtl/mem_dma.sv | 167 ++++++++++++++++
 tb/tb_mem_dma.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_dma.sv
// rtl/mem_dma.sv - single-channel memory DMA engine: word copy and constant fill
//
// Moves words inside one attached data memory that has a registered read
// port (data valid one cycle after the address) and an independent write port.
//
// Ports:
//   clk         rising-edge clock
//   reset       asynchronous, active-high reset
//   start       transfer request, honoured only while idle
//   mode        0 = copy, 1 = fill (sampled with start)
//   src_addr    copy source base address (sampled with start)
//   dst_addr    destination base address (sampled with start)
//   length      word count 0..2^ADDR_WIDTH (sampled with start)
//   fill_value  word written in fill mode (sampled with start)
//   busy        high while a transfer is in progress
//   done        one-cycle completion pulse
//   mem_addr_r  memory read address
//   mem_data_r  memory read data, one cycle after mem_addr_r
//   mem_addr_w  memory write address
//   mem_data_w  memory write data
//   mem_we      memory write enable

module mem_dma #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  mode,
    input  logic [ADDR_WIDTH-1:0] src_addr,
    input  logic [ADDR_WIDTH-1:0] dst_addr,
    input  logic [ADDR_WIDTH:0]   length,
    input  logic [DATA_WIDTH-1:0] fill_value,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] mem_addr_r,
    input  logic [DATA_WIDTH-1:0] mem_data_r,
    output logic [ADDR_WIDTH-1:0] mem_addr_w,
    output logic [DATA_WIDTH-1:0] mem_data_w,
    output logic                  mem_we
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COPY  = 2'd1,
        DRAIN = 2'd2,
        FILL  = 2'd3
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [ADDR_WIDTH:0]   CNT_ONE  = {{ADDR_WIDTH{1'b0}}, 1'b1};

    state_t                state;
    state_t                state_next;

    // Words still to be read (copy) or written (fill); one bit wider than an
    // address so a full-memory transfer fits.
    logic [ADDR_WIDTH:0]   cnt;
    logic [DATA_WIDTH-1:0] fill_q;
    // Set once the first copy read has been issued: from then on every COPY
    // cycle also retires the word read in the previous cycle.
    logic                  wr_pend;

    logic                  accept;
    logic                  zero_len;

    assign accept   = (state == IDLE) && start;
    assign zero_len = (length == '0);

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state and combinational outputs.
    always_comb begin
        state_next = state;
        busy       = 1'b0;
        mem_we     = 1'b0;
        mem_data_w = mem_data_r;
        case (state)
            IDLE: begin
                if (start && !zero_len) begin
                    state_next = mode ? FILL : COPY;
                end
            end
            COPY: begin
                busy   = 1'b1;
                mem_we = wr_pend;
                if (cnt == CNT_ONE) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                // Retire the last word read in COPY.
                busy       = 1'b1;
                mem_we     = 1'b1;
                state_next = IDLE;
            end
            FILL: begin
                busy       = 1'b1;
                mem_we     = 1'b1;
                mem_data_w = fill_q;
                if (cnt == CNT_ONE) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Datapath: operand latches, address walkers, counter and done pulse.
    // mem_addr_r holds the latched source base and mem_addr_w the latched
    // destination base, so they double as the walking addresses.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_addr_r <= '0;
            mem_addr_w <= '0;
            cnt        <= '0;
            fill_q     <= '0;
            wr_pend    <= 1'b0;
            done       <= 1'b0;
        end else begin
            done <= (accept && zero_len)
                 || (state == DRAIN)
                 || ((state == FILL) && (cnt == CNT_ONE));

            case (state)
                IDLE: begin
                    wr_pend <= 1'b0;
                    if (accept) begin
                        mem_addr_r <= src_addr;
                        mem_addr_w <= dst_addr;
                        cnt        <= length;
                        fill_q     <= fill_value;
                    end
                end
                COPY: begin
                    mem_addr_r <= mem_addr_r + ADDR_ONE;
                    cnt        <= cnt - CNT_ONE;
                    wr_pend    <= 1'b1;
                    if (wr_pend) begin
                        mem_addr_w <= mem_addr_w + ADDR_ONE;
                    end
                end
                DRAIN: begin
                    wr_pend <= 1'b0;
                end
                FILL: begin
                    mem_addr_w <= mem_addr_w + ADDR_ONE;
                    cnt        <= cnt - CNT_ONE;
                end
                default: begin
                    wr_pend <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_dma.sv
// tb/tb_mem_dma.sv - self-checking bench for mem_dma with a transfer-level memory model

module tb_mem_dma;

    localparam int DW = 16;
    localparam int AW = 8;

    localparam int OP_NONE = 0;
    localparam int OP_COPY = 1;
    localparam int OP_FILL = 2;
    localparam int OP_ZERO = 3;

    logic          clk;
    logic          reset;
    logic          start;
    logic          mode;
    logic [AW-1:0] src_addr;
    logic [AW-1:0] dst_addr;
    logic [AW:0]   length;
    logic [DW-1:0] fill_value;
    logic          busy;
    logic          done;
    logic [AW-1:0] mem_addr_r;
    logic [DW-1:0] mem_data_r;
    logic [AW-1:0] mem_addr_w;
    logic [DW-1:0] mem_data_w;
    logic          mem_we;

    mem_dma #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .mode       (mode),
        .src_addr   (src_addr),
        .dst_addr   (dst_addr),
        .length     (length),
        .fill_value (fill_value),
        .busy       (busy),
        .done       (done),
        .mem_addr_r (mem_addr_r),
        .mem_data_r (mem_data_r),
        .mem_addr_w (mem_addr_w),
        .mem_data_w (mem_data_w),
        .mem_we     (mem_we)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Attached memory: registered read returning old data on a same-address write.
    logic [DW-1:0] mem [0:255];
    int            wr_cnt = 0;
    always @(posedge clk) begin
        mem_data_r <= mem[mem_addr_r];
        if (mem_we === 1'b1) begin
            mem[mem_addr_w] <= mem_data_w;
            wr_cnt          <= wr_cnt + 1;
        end
    end

    int n_checks = 0;
    int n_pass   = 0;
    bit cmp_en   = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    // Transfer-level model: which transfer is running and which cycle of it
    // (cycle 0 = the cycle after the accepting edge).
    logic [DW-1:0] ref_mem [0:255];
    logic [DW-1:0] snap    [0:255];
    int            m_op  = OP_NONE;
    int            m_k   = 0;
    int            m_len = 0;
    int            m_src = 0;
    int            m_dst = 0;
    logic [DW-1:0] m_fill = '0;

    function automatic bit exp_busy_f();
        return ((m_op == OP_COPY) && (m_k <= m_len)) || ((m_op == OP_FILL) && (m_k < m_len));
    endfunction

    function automatic int done_cycle_f();
        if (m_op == OP_COPY) return m_len + 1;
        if (m_op == OP_FILL) return m_len;
        return 0;
    endfunction

    function automatic bit exp_done_f();
        return (m_op != OP_NONE) && (m_k == done_cycle_f());
    endfunction

    function automatic bit exp_we_f();
        return ((m_op == OP_COPY) && (m_k >= 1) && (m_k <= m_len))
            || ((m_op == OP_FILL) && (m_k < m_len));
    endfunction

    function automatic int exp_addr_w_f();
        if (m_op == OP_COPY) return (m_dst + m_k - 1) & 255;
        return (m_dst + m_k) & 255;
    endfunction

    function automatic logic [DW-1:0] exp_data_w_f();
        if (m_op == OP_COPY) return snap[m_k - 1];
        return m_fill;
    endfunction

    task automatic model_step();
        if (reset) begin
            m_op = OP_NONE;
            m_k  = 0;
            return;
        end
        if (exp_we_f()) ref_mem[exp_addr_w_f()] = exp_data_w_f();
        if (start && !exp_busy_f()) begin
            m_len  = int'(length);
            m_src  = int'(src_addr);
            m_dst  = int'(dst_addr);
            m_fill = fill_value;
            m_k    = 0;
            if (m_len == 0) begin
                m_op = OP_ZERO;
            end else if (mode) begin
                m_op = OP_FILL;
            end else begin
                m_op = OP_COPY;
                for (int i = 0; i < m_len; i++) snap[i] = ref_mem[(m_src + i) & 255];
            end
        end else if (m_op != OP_NONE) begin
            m_k++;
            if (m_k > done_cycle_f()) m_op = OP_NONE;
        end
    endtask

    initial forever begin
        @(posedge clk or posedge reset);
        model_step();
    end

    // Per-cycle comparison against the model.
    initial forever begin
        @(negedge clk);
        if (cmp_en) begin
            chk("busy", {31'd0, busy}, {31'd0, exp_busy_f()});
            chk("done", {31'd0, done}, {31'd0, exp_done_f()});
            chk("mem_we", {31'd0, mem_we}, {31'd0, exp_we_f()});
            if (exp_we_f()) begin
                chk("mem_addr_w", {24'd0, mem_addr_w}, exp_addr_w_f());
                chk("mem_data_w", {16'd0, mem_data_w}, {16'd0, exp_data_w_f()});
            end
            if ((m_op == OP_COPY) && (m_k < m_len)) begin
                chk("mem_addr_r", {24'd0, mem_addr_r}, (m_src + m_k) & 255);
            end
        end
    end

    task automatic poke(input int a, input logic [DW-1:0] d);
        mem[a & 255]     = d;
        ref_mem[a & 255] = d;
    endtask

    // Presents a start for one edge, then scrambles the operands; returns in cycle 0.
    task automatic issue_start(input logic m, input logic [AW-1:0] s, input logic [AW-1:0] d,
                               input logic [AW:0] l, input logic [DW-1:0] f);
        @(negedge clk);
        #1;
        start      = 1'b1;
        mode       = m;
        src_addr   = s;
        dst_addr   = d;
        length     = l;
        fill_value = f;
        @(negedge clk);
        #1;
        start      = 1'b0;
        mode       = ~m;
        src_addr   = AW'($urandom);
        dst_addr   = AW'($urandom);
        length     = (AW+1)'($urandom);
        fill_value = DW'($urandom);
    endtask

    task automatic wait_done(input int k0, output int k);
        k = -1;
        for (int i = k0; i < k0 + 600; i++) begin
            if (done === 1'b1) begin
                k = i;
                return;
            end
            @(negedge clk);
            #1;
        end
    endtask

    task automatic mem_vs_model(input string name);
        int errs;
        errs = 0;
        for (int i = 0; i < 256; i++) if (mem[i] !== ref_mem[i]) errs++;
        chk(name, errs, 0);
    endtask

    int k;
    int w0;
    int errs;

    initial begin
        reset      = 1'b1;
        start      = 1'b0;
        mode       = 1'b0;
        src_addr   = '0;
        dst_addr   = '0;
        length     = '0;
        fill_value = '0;
        for (int i = 0; i < 256; i++) poke(i, DW'(i * 7 + 3));

        #12;
        chk("rst_busy", {31'd0, busy}, 0);
        chk("rst_done", {31'd0, done}, 0);
        chk("rst_we", {31'd0, mem_we}, 0);
        chk("rst_addr_r", {24'd0, mem_addr_r}, 0);
        chk("rst_addr_w", {24'd0, mem_addr_w}, 0);
        @(negedge clk);
        #1;
        reset  = 1'b0;
        cmp_en = 1'b1;

        // Copy 4 words 0x10 -> 0x80.
        for (int i = 0; i < 4; i++) poke(16'h10 + i, DW'(16'h1000 + i));
        issue_start(1'b0, 8'h10, 8'h80, 9'd4, 16'h0);
        w0 = wr_cnt;
        wait_done(0, k);
        chk("copy_done_cycle", k, 5);
        chk("copy_writes", wr_cnt - w0, 4);
        chk("copy_m80", {16'd0, mem[8'h80]}, 32'h1000);
        chk("copy_m81", {16'd0, mem[8'h81]}, 32'h1001);
        chk("copy_m82", {16'd0, mem[8'h82]}, 32'h1002);
        chk("copy_m83", {16'd0, mem[8'h83]}, 32'h1003);

        // Fill with address wrap.
        poke(2, 16'h2222);
        issue_start(1'b1, 8'h00, 8'hFE, 9'd4, 16'hBEEF);
        wait_done(0, k);
        chk("fillw_done_cycle", k, 4);
        chk("fillw_mFE", {16'd0, mem[8'hFE]}, 32'hBEEF);
        chk("fillw_mFF", {16'd0, mem[8'hFF]}, 32'hBEEF);
        chk("fillw_m00", {16'd0, mem[8'h00]}, 32'hBEEF);
        chk("fillw_m01", {16'd0, mem[8'h01]}, 32'hBEEF);
        chk("fillw_m02", {16'd0, mem[8'h02]}, 32'h2222);

        // Zero length.
        issue_start(1'b0, 8'h10, 8'h90, 9'd0, 16'h0);
        w0 = wr_cnt;
        wait_done(0, k);
        chk("zero_done_cycle", k, 0);
        @(negedge clk);
        #1;
        chk("zero_writes", wr_cnt - w0, 0);

        // Shift-by-one copy.
        for (int i = 0; i < 4; i++) poke(16'h20 + i, DW'(i + 1));
        poke(16'h24, 16'h5555);
        issue_start(1'b0, 8'h20, 8'h21, 9'd4, 16'h0);
        wait_done(0, k);
        chk("shift_done_cycle", k, 5);
        for (int i = 0; i < 4; i++) chk("shift_mem", {16'd0, mem[8'h21 + i]}, i + 1);

        // Start while busy is ignored; start in the done cycle is accepted.
        issue_start(1'b0, 8'h40, 8'hC0, 9'd8, 16'h0);
        w0 = wr_cnt;
        repeat (2) begin
            @(negedge clk);
            #1;
        end
        start      = 1'b1;
        mode       = 1'b1;
        dst_addr   = 8'h00;
        length     = 9'd3;
        fill_value = 16'hDEAD;
        @(negedge clk);
        #1;
        start = 1'b0;
        wait_done(3, k);
        chk("busy_done_cycle", k, 9);
        chk("busy_writes", wr_cnt - w0, 8);
        start      = 1'b1;
        mode       = 1'b1;
        dst_addr   = 8'h30;
        length     = 9'd2;
        fill_value = 16'h1234;
        @(negedge clk);
        #1;
        start = 1'b0;
        wait_done(0, k);
        chk("b2b_done_cycle", k, 2);
        chk("b2b_m30", {16'd0, mem[8'h30]}, 32'h1234);
        chk("b2b_m31", {16'd0, mem[8'h31]}, 32'h1234);

        // Reset in cycle 3 of an 8-word fill.
        issue_start(1'b1, 8'h00, 8'h60, 9'd8, 16'h7777);
        w0 = wr_cnt;
        repeat (3) begin
            @(negedge clk);
            #1;
        end
        reset = 1'b1;
        #1;
        chk("abort_busy", {31'd0, busy}, 0);
        chk("abort_we", {31'd0, mem_we}, 0);
        chk("abort_addr_w", {24'd0, mem_addr_w}, 0);
        @(negedge clk);
        #1;
        reset = 1'b0;
        repeat (4) begin
            chk("abort_no_done", {31'd0, done}, 0);
            @(negedge clk);
            #1;
        end
        chk("abort_writes", wr_cnt - w0, 3);
        mem_vs_model("mem_vs_model_a");

        // Full-memory fill.
        issue_start(1'b1, 8'h00, 8'h00, 9'd256, 16'hA5A5);
        w0 = wr_cnt;
        wait_done(0, k);
        chk("full_done_cycle", k, 256);
        chk("full_writes", wr_cnt - w0, 256);
        errs = 0;
        for (int i = 0; i < 256; i++) if (mem[i] !== 16'hA5A5) errs++;
        chk("full_content", errs, 0);
        mem_vs_model("mem_vs_model_b");

        @(negedge clk);
        cmp_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
